// File: rtl/clk_div_pkg.sv
// Shared definitions for the board clock divider controller.
//   state_t      : controller sequencing states
//   CNT_W_DEF    : default width of the divide counter / terminal count
//   DIV_*        : half-period terminal counts for a 100 MHz input clock
//                  (half-period = div + 1 input cycles)
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP
  } state_t;

  localparam int unsigned CNT_W_DEF = 17;

  localparam int unsigned DIV_1MHZ = 49;
  localparam int unsigned DIV_1KHZ = 49_999;
  // Needs CNT_W >= 26.
  localparam int unsigned DIV_1HZ  = 49_999_999;

endpackage

// File: rtl/clk_div_ctrl_div_counter.sv
// Divide counter with terminal-count compare and divided-clock toggle.
//   clk, reset : system clock, synchronous active-high reset
//   run        : 1 = count, 0 = hold counter/clk_out/tick at 0
//   div        : terminal count (half-period = div + 1 cycles)
//   clk_out    : registered divided clock
//   tick       : registered one-cycle pulse alongside each clk_out edge
//   terminal   : counter is at the terminal count this cycle
//   falling    : terminal count while clk_out is high (clk_out about to fall)
module div_counter #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             terminal,
  output logic             falling
);

  logic [CNT_W-1:0] count;

  assign terminal = (count == div);
  assign falling  = terminal && clk_out;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (terminal) begin
      count   <= '0;
      clk_out <= ~clk_out;
      tick    <= 1'b1;
    end else begin
      count   <= count + CNT_W'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the board clock divider.
// Starts/stops the divided clock on full-period boundaries and accepts new
// divide ratios over a valid/ready handshake, applying them only when
// clk_out falls so every clk_out period uses a single ratio.
//   clk, reset : system clock, synchronous active-high reset
//   en         : 1 = run divided clock, 0 = stop at next falling boundary
//   cfg_valid  : new terminal count offered
//   cfg_div    : new terminal count
//   cfg_ready  : controller can accept a config
//   clk_out    : divided clock, period 2*(div+1) cycles
//   tick       : one-cycle pulse on every clk_out edge
//   running    : controller is not idle
//   active_div : terminal count currently in use
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_1KHZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] active_div
);

  state_t           state;
  state_t           next_state;
  logic             run;
  logic             terminal;
  logic             falling;
  logic             xfer;
  logic [CNT_W-1:0] pend_div;
  logic             pend_flag;

  assign run  = (state != ST_IDLE);
  assign xfer = cfg_valid && cfg_ready;

  div_counter #(
    .CNT_W (CNT_W)
  ) u_div_counter (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .div      (active_div),
    .clk_out  (clk_out),
    .tick     (tick),
    .terminal (terminal),
    .falling  (falling)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state != ST_IDLE);
    end
  end

  // en=1 in STOP wins over a coincident falling boundary: the clock keeps
  // running rather than stopping and restarting.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (en) next_state = ST_RUN;
      ST_RUN:  if (!en) next_state = ST_STOP;
      ST_STOP: begin
        if (en)           next_state = ST_RUN;
        else if (falling) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // cfg_ready is low exactly while a pending ratio is held, so a transfer
  // never coincides with a pending apply; a transfer on a falling boundary
  // therefore waits for the following one.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_div <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_flag  <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      if (run && falling && pend_flag) begin
        active_div <= pend_div;
        pend_flag  <= 1'b0;
        cfg_ready  <= 1'b1;
      end
      if (xfer) begin
        if (state == ST_IDLE) begin
          active_div <= cfg_div;
        end else begin
          pend_div  <= cfg_div;
          pend_flag <= 1'b1;
          cfg_ready <= 1'b0;
        end
      end
    end
  end

  // terminal is folded into falling; kept visible for debug probing.
  logic unused_terminal;
  assign unused_terminal = terminal;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  localparam int unsigned W   = 17;
  localparam int unsigned DEF = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         clk_out;
  logic         tick;
  logic         running;
  logic [W-1:0] active_div;

  clk_div_ctrl #(
    .CNT_W       (W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running),
    .active_div (active_div)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: position within the current clk_out period.
  // Low half is positions 0..d, high half d+1..2d+1.
  bit          m_active, m_drain, m_tick, m_pend_v;
  int unsigned m_pos, m_d, m_pend;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          xfer;
    int unsigned period;
    if (reset) begin
      m_active = 0; m_drain = 0; m_tick = 0; m_pend_v = 0;
      m_pos = 0; m_d = DEF; m_pend = 0;
      return;
    end
    xfer = cfg_valid && !m_pend_v;
    if (!m_active) begin
      m_tick = 0;
      if (xfer) m_d = cfg_div;
      if (en) begin
        m_active = 1; m_drain = 0; m_pos = 0;
      end
    end else begin
      period = 2 * (m_d + 1);
      m_tick = (m_pos == m_d) || (m_pos == period - 1);
      if (m_pos == period - 1) begin
        m_pos = 0;
        if (m_drain && !en) m_active = 0;
        if (m_pend_v) begin
          m_d = m_pend; m_pend_v = 0;
        end
      end else begin
        m_pos++;
      end
      m_drain = !en;
      if (xfer) begin
        m_pend = cfg_div; m_pend_v = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("clk_out",    clk_out,    (m_active && m_pos >= m_d + 1) ? 1 : 0);
    chk("tick",       tick,       m_tick);
    chk("running",    running,    m_active);
    chk("cfg_ready",  cfg_ready,  !m_pend_v);
    chk("active_div", active_div, m_d);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1; en = 0; cfg_valid = 0;
    step();
    reset = 0;
  endtask

  task automatic wait_tick(input bit lvl, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (tick && clk_out == lvl) found = 1;
    end
    if (!found) chk("wait_tick_timeout", 0, 1);
  endtask

  task automatic measure_period(input int exp);
    int n = 0;
    bit found = 0;
    wait_tick(1, 100);
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      n++;
      if (tick && clk_out) found = 1;
    end
    chk("period", n, exp);
  endtask

  task automatic send_cfg(input int unsigned d);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (cfg_ready) found = 1;
      else step();
    end
    if (!found) chk("cfg_ready_timeout", 0, 1);
    cfg_valid = 1; cfg_div = W'(d);
    step();
    cfg_valid = 0;
  endtask

  typedef struct {
    bit          rst;
    bit          en;
    bit          clko;
    bit          tk;
    bit          run;
    bit          rdy;
    int unsigned ad;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Startup from reset at div 3: tick at cycles 5, 9, 13; 4 low / 4 high.
    tbl[0] = '{rst: 1, en: 0, clko: 0, tk: 0, run: 0, rdy: 1, ad: DEF};
    for (int c = 1; c < 15; c++)
      tbl[c] = '{rst: 0, en: 1, clko: bit'(((c - 1) / 4) % 2),
                 tk: (c >= 5 && (c - 1) % 4 == 0), run: 1, rdy: 1, ad: DEF};

    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst; en = tbl[i].en; cfg_valid = 0;
      step();
      chk("tbl_clk_out",    clk_out,    tbl[i].clko);
      chk("tbl_tick",       tick,       tbl[i].tk);
      chk("tbl_running",    running,    tbl[i].run);
      chk("tbl_cfg_ready",  cfg_ready,  tbl[i].rdy);
      chk("tbl_active_div", active_div, tbl[i].ad);
    end

    // Config in IDLE applies next cycle, ready stays high; then period 4.
    do_reset();
    cfg_valid = 1; cfg_div = 1;
    step();
    cfg_valid = 0;
    chk("idle_cfg_ad",  active_div, 1);
    chk("idle_cfg_rdy", cfg_ready,  1);
    en = 1;
    measure_period(4);

    // Config 7 during low half at div 3: ready low until falling boundary.
    do_reset();
    en = 1;
    wait_tick(1, 50);
    wait_tick(0, 50);
    step();
    cfg_valid = 1; cfg_div = 7;
    step();
    cfg_valid = 0;
    chk("run_cfg_rdy_low", cfg_ready, 0);
    for (int i = 0; i < 40; i++) step();
    measure_period(16);

    // Drop en with clk_out high, counter 1: high two more cycles, then idle.
    do_reset();
    en = 1;
    wait_tick(1, 50);
    step();
    en = 0;
    step();
    chk("stop_high1", clk_out, 1);
    step();
    chk("stop_high2", clk_out, 1);
    step();
    chk("stop_fall", clk_out, 0);
    chk("stop_idle", running, 0);

    // Re-raise en while draining: periods continue undisturbed.
    en = 1;
    wait_tick(1, 50);
    en = 0;
    step();
    en = 1;
    step();
    measure_period(8);

    // div 0 gives clk/2 with tick held high; back to 3 restores period 8.
    send_cfg(0);
    wait_tick(1, 100);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("div0_tick", tick, 1);
    end
    send_cfg(3);
    for (int i = 0; i < 10; i++) step();
    measure_period(8);

    // Reset with a pending config discards it.
    send_cfg(7);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("rst_clk_out", clk_out,    0);
    chk("rst_ad",      active_div, DEF);
    chk("rst_rdy",     cfg_ready,  1);
    chk("rst_running", running,    0);
    en = 1;
    measure_period(8);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = W'($urandom_range(0, 5));
      reset     = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0; cfg_valid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
